// File: rtl/fan_pkg.sv
// Shared widths, line field offsets and drain state encoding
// for the fan_adder row accumulator.
package fan_pkg;

    localparam int DW_DATA = 8;
    localparam int DW_ROW  = 5;
    localparam int DW_CTRL = 4;
    localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
    localparam int DW_ACC  = 16;
    localparam int NUM_ROW = 2 ** DW_ROW;

    // Line layout is {ctrl,row,data}, data in the LSBs
    localparam int OFS_DATA = 0;
    localparam int OFS_ROW  = DW_DATA;
    localparam int OFS_CTRL = DW_DATA + DW_ROW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_OUT,
        ST_DONE
    } drain_st_e;

endpackage

// File: rtl/fan_acc_bank.sv
// One accumulator bank: NUM_ROW sums plus touched bits,
// with a write port, a row-clear port and a combinational read.
module fan_acc_bank
    import fan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              add_en_i,
    input  logic [DW_ROW-1:0] add_row_i,
    input  logic [DW_ACC-1:0] add_val_i,
    input  logic              clr_en_i,
    input  logic [DW_ROW-1:0] clr_row_i,
    input  logic [DW_ROW-1:0] rd_row_i,
    output logic [DW_ACC-1:0] rd_acc_o,
    output logic              rd_touch_o
);

    logic [NUM_ROW-1:0][DW_ACC-1:0] acc_q;
    logic [NUM_ROW-1:0]             tch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            tch_q <= '0;
        end else begin
            if (add_en_i) begin
                acc_q[add_row_i] <= add_val_i;
                tch_q[add_row_i] <= 1'b1;
            end
            if (clr_en_i) begin
                acc_q[clr_row_i] <= '0;
                tch_q[clr_row_i] <= 1'b0;
            end
        end
    end

    assign rd_acc_o   = acc_q[rd_row_i];
    assign rd_touch_o = tch_q[rd_row_i];

endmodule

// File: rtl/fan_row_accum.sv
// Per-row ping-pong accumulator behind fan_adder; a closed bank
// is drained in ascending row order over a valid/ready port.
module fan_row_accum
    import fan_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW_LINE-1:0] in_line,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW_ROW-1:0]  out_row,
    output logic [DW_ACC-1:0]  out_data,
    output logic               busy,
    output logic               ovf,
    output logic               flush_err
);

    logic [DW_CTRL-1:0] ctrl;
    logic [DW_ROW-1:0]  row;
    logic [DW_DATA-1:0] data;
    logic               in_vld;
    logic               ctrl_unused;

    assign ctrl        = in_line[OFS_CTRL +: DW_CTRL];
    assign row         = in_line[OFS_ROW +: DW_ROW];
    assign data        = in_line[OFS_DATA +: DW_DATA];
    assign in_vld      = ctrl[DW_CTRL-1];
    assign ctrl_unused = ^ctrl[DW_CTRL-2:0];

    drain_st_e         st_q, st_d;
    logic              act_q, act_d;
    logic [DW_ROW-1:0] ptr_q, ptr_d;
    logic [DW_ROW-1:0] orow_q, orow_d;
    logic [DW_ACC-1:0] odat_q, odat_d;
    logic              ovf_q, ovf_d;
    logic              ferr_q, ferr_d;

    logic [1:0]              add_en;
    logic [1:0]              clr_en;
    logic [1:0]              rd_tch;
    logic [1:0][DW_ROW-1:0]  rd_row;
    logic [1:0][DW_ACC-1:0]  rd_acc;
    logic                    drn;
    logic                    hs;
    logic                    last;
    logic [DW_ACC:0]         sum_w;
    logic [DW_ACC-1:0]       sum_sat;

    assign drn  = ~act_q;
    assign hs   = (st_q == ST_OUT) && out_ready;
    assign last = (ptr_q == DW_ROW'(NUM_ROW - 1));

    // One spare bit catches the carry that triggers saturation
    assign sum_w   = {1'b0, rd_acc[act_q]} + (DW_ACC + 1)'(data);
    assign sum_sat = sum_w[DW_ACC] ? '1 : sum_w[DW_ACC-1:0];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic ID = 1'(b);

        assign rd_row[b] = (act_q == ID) ? row : ptr_q;
        assign add_en[b] = in_vld && (act_q == ID);
        assign clr_en[b] = hs && (act_q != ID);

        fan_acc_bank u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .add_en_i   (add_en[b]),
            .add_row_i  (row),
            .add_val_i  (sum_sat),
            .clr_en_i   (clr_en[b]),
            .clr_row_i  (ptr_q),
            .rd_row_i   (rd_row[b]),
            .rd_acc_o   (rd_acc[b]),
            .rd_touch_o (rd_tch[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            act_q  <= 1'b0;
            ptr_q  <= '0;
            orow_q <= '0;
            odat_q <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            act_q  <= act_d;
            ptr_q  <= ptr_d;
            orow_q <= orow_d;
            odat_q <= odat_d;
            ovf_q  <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    always_comb begin
        st_d   = st_q;
        act_d  = act_q;
        ptr_d  = ptr_q;
        orow_d = orow_q;
        odat_d = odat_q;
        ovf_d  = ovf_q | (in_vld & sum_w[DW_ACC]);
        ferr_d = ferr_q | (flush & (st_q != ST_IDLE));

        unique case (st_q)
            ST_IDLE: begin
                if (flush) begin
                    act_d = ~act_q;
                    ptr_d = '0;
                    st_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (rd_tch[drn]) begin
                    orow_d = ptr_q;
                    odat_d = rd_acc[drn];
                    st_d   = ST_OUT;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                    st_d  = last ? ST_DONE : ST_SCAN;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    ptr_d = ptr_q + 1'b1;
                    st_d  = last ? ST_DONE : ST_SCAN;
                end
            end
            ST_DONE: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    assign out_valid = (st_q == ST_OUT);
    assign busy      = (st_q != ST_IDLE);
    assign out_row   = orow_q;
    assign out_data  = odat_q;
    assign ovf       = ovf_q;
    assign flush_err = ferr_q;

endmodule

// File: tb/tb_fan_row_accum.sv
// Randomized and directed bench for fan_row_accum against a
// bank-level reference model with an expected-beat queue.
module tb_fan_row_accum;
    import fan_pkg::*;

    localparam int MAXV = (1 << DW_ACC) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DW_LINE-1:0] in_line = '0;
    logic               flush = 1'b0;
    logic               out_ready = 1'b0;
    logic               out_valid;
    logic [DW_ROW-1:0]  out_row;
    logic [DW_ACC-1:0]  out_data;
    logic               busy;
    logic               ovf;
    logic               flush_err;

    always #5 clk = ~clk;

    fan_row_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_line   (in_line),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .busy      (busy),
        .ovf       (ovf),
        .flush_err (flush_err)
    );

    typedef struct {
        int row;
        int data;
    } beat_t;

    beat_t expq[$];
    int    macc[2][NUM_ROW];
    bit    mtch[2][NUM_ROW];
    int    mact;
    bit    movf;
    bit    mferr;
    bit    mbusy;
    int    n_chk;
    int    n_fail;
    int    stall_left;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < NUM_ROW; r++) begin
                macc[b][r] = 0;
                mtch[b][r] = 1'b0;
            end
        mact  = 0;
        movf  = 1'b0;
        mferr = 1'b0;
        mbusy = 1'b0;
        expq.delete();
    endtask

    // Drive one cycle at the falling edge, check outputs, update model
    task automatic step(input logic [3:0] c, input int r, input int d,
                        input bit fl, input bit rdy);
        int    s;
        beat_t bt;
        @(negedge clk);
        chk("ovf", 32'(ovf), 32'(movf));
        chk("flush_err", 32'(flush_err), 32'(mferr));
        in_line   = {c, 5'(r), 8'(d)};
        flush     = fl;
        out_ready = rdy;
        if (out_valid && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end
        if (out_valid) begin
            if (expq.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                chk("out_row", 32'(out_row), expq[0].row);
                chk("out_data", 32'(out_data), expq[0].data);
                if (out_ready) void'(expq.pop_front());
            end
        end
        if (c[3]) begin
            s = macc[mact][r] + d;
            if (s > MAXV) begin
                s    = MAXV;
                movf = 1'b1;
            end
            macc[mact][r] = s;
            mtch[mact][r] = 1'b1;
        end
        if (fl) begin
            if (mbusy) begin
                mferr = 1'b1;
            end else begin
                for (int rr = 0; rr < NUM_ROW; rr++) begin
                    if (mtch[mact][rr]) begin
                        bt.row  = rr;
                        bt.data = macc[mact][rr];
                        expq.push_back(bt);
                    end
                    macc[mact][rr] = 0;
                    mtch[mact][rr] = 1'b0;
                end
                mact  = mact ^ 1;
                mbusy = 1'b1;
            end
        end
    endtask

    task automatic idle(input bit rnd);
        logic [3:0] c;
        int         r;
        if (rnd) begin
            c = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7) c[3] = 1'b1;
            r = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_ROW - 1)
                                            : $urandom_range(0, 7);
            step(c, r, $urandom_range(0, 255), 1'b0,
                 $urandom_range(0, 3) != 0);
        end else begin
            step(4'b0000, 0, 0, 1'b0, 1'b1);
        end
    endtask

    task automatic wait_idle(input bit rnd);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            idle(rnd);
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        chk("drain_done", 32'(done), 1);
        chk("beats_left", expq.size(), 0);
        mbusy = 1'b0;
    endtask

    initial begin
        int  cnt;
        bit  seen;
        n_chk      = 0;
        n_fail     = 0;
        stall_left = 0;
        model_reset();

        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out_row", 32'(out_row), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_flush_err", 32'(flush_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic accumulate and drain
        step(4'b1000, 3, 5, 1'b0, 1'b1);
        step(4'b1000, 3, 2, 1'b0, 1'b1);
        step(4'b1000, 0, 1, 1'b0, 1'b1);
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        chk("basic_beats", expq.size(), 2);
        wait_idle(1'b0);

        // Backpressure on the first beat
        step(4'b1000, 3, 5, 1'b0, 1'b1);
        step(4'b1000, 3, 2, 1'b0, 1'b1);
        step(4'b1000, 0, 1, 1'b0, 1'b1);
        stall_left = 3;
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        wait_idle(1'b0);
        chk("stall_used", stall_left, 0);

        // Saturation with interleaved invalid lines
        for (int i = 0; i < 258; i++) begin
            step(4'b1000, 1, 255, 1'b0, 1'b1);
            step(4'b0100, 1, 255, 1'b0, 1'b1);
        end
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        wait_idle(1'b0);
        chk("ovf_sticky", 32'(ovf), 1);

        // Ping-pong with a flush while busy
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        step(4'b1000, 2, 9, 1'b0, 1'b1);
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        wait_idle(1'b0);
        chk("flush_err_set", 32'(flush_err), 1);
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        chk("pingpong_beats", expq.size(), 1);
        wait_idle(1'b0);

        // Line in the flush cycle, then an empty-bank drain
        step(4'b1000, 31, 4, 1'b1, 1'b1);
        chk("row31_beats", expq.size(), 1);
        wait_idle(1'b0);
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            idle(1'b0);
            if (busy) cnt++;
            else break;
        end
        chk("empty_busy_cycles", cnt, NUM_ROW + 1);
        chk("empty_beats", expq.size(), 0);
        mbusy = 1'b0;

        // Random traffic with random backpressure
        for (int k = 0; k < 8; k++) begin
            int n;
            n = $urandom_range(10, 60);
            for (int i = 0; i < n; i++) idle(1'b1);
            step(4'b1000, $urandom_range(0, 7), $urandom_range(0, 255),
                 1'b1, 1'b1);
            wait_idle(1'b1);
        end

        // Reset in the middle of a held beat
        step(4'b1000, 4, 3, 1'b0, 1'b1);
        step(4'b1000, 6, 7, 1'b0, 1'b1);
        stall_left = 1000;
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            idle(1'b0);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk("reached_out", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_out_data", 32'(out_data), 0);
        chk("arst_flush_err", 32'(flush_err), 0);
        chk("arst_ovf", 32'(ovf), 0);
        model_reset();
        stall_left = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0000, 0, 0, 1'b1, 1'b1);
        chk("post_rst_beats", expq.size(), 0);
        wait_idle(1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
